// File: rtl/count_monitor.sv
// count_monitor: watches an upstream 4-bit counter, locks after a run
// of correct steps, and logs wraps and in-lock mismatches.
module count_monitor #(
  parameter int unsigned LOCK_N = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic       en,
  input  logic       cnt_rst,
  input  logic       clr_err,
  output logic       locked,
  output logic       wrap_pulse,
  output logic [7:0] wrap_cnt,
  output logic       err,
  output logic [7:0] err_cnt,
  output logic [3:0] last_bad
);

  typedef enum logic [1:0] {
    ACQ,
    TRACK,
    LOCK
  } state_t;

  state_t     state, state_n;
  logic [3:0] prev_q;
  logic [3:0] gcnt, gcnt_n;
  logic [3:0] expd;
  logic       good;
  logic       bad;
  logic       wrap;

  always_comb begin
    expd    = en ? prev_q + 4'd1 : prev_q;
    good    = (q_in == expd);
    state_n = state;
    gcnt_n  = gcnt;
    bad     = 1'b0;
    wrap    = 1'b0;
    if (cnt_rst) begin
      state_n = ACQ;
      gcnt_n  = 4'd0;
    end else begin
      wrap = (state != ACQ) && (prev_q == 4'hf)
          && en && (q_in == 4'h0);
      unique case (state)
        ACQ: begin
          state_n = TRACK;
          gcnt_n  = 4'd0;
        end
        TRACK: begin
          if (good) begin
            gcnt_n = gcnt + 4'd1;
            if (gcnt_n == LOCK_N[3:0])
              state_n = LOCK;
          end else begin
            gcnt_n = 4'd0;
          end
        end
        LOCK: begin
          if (!good) begin
            bad     = 1'b1;
            gcnt_n  = 4'd0;
            state_n = TRACK;
          end
        end
        default: begin
          state_n = ACQ;
          gcnt_n  = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ACQ;
      gcnt       <= 4'd0;
      prev_q     <= 4'd0;
      locked     <= 1'b0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= 8'd0;
      err        <= 1'b0;
      err_cnt    <= 8'd0;
      last_bad   <= 4'd0;
    end else begin
      state      <= state_n;
      gcnt       <= gcnt_n;
      prev_q     <= q_in;
      locked     <= (state_n == LOCK);
      wrap_pulse <= wrap;
      if (wrap && wrap_cnt != 8'hff)
        wrap_cnt <= wrap_cnt + 8'd1;
      // a same-cycle mismatch beats the clear
      if (bad) begin
        err      <= 1'b1;
        last_bad <= q_in;
        if (clr_err)
          err_cnt <= 8'd1;
        else if (err_cnt != 8'hff)
          err_cnt <= err_cnt + 8'd1;
      end else if (clr_err) begin
        err      <= 1'b0;
        err_cnt  <= 8'd0;
        last_bad <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_count_monitor.sv
// tb_count_monitor: directed scenarios plus randomized traffic checked
// against a behavioural model of the monitor.
module tb_count_monitor;

  localparam int LOCK_N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] q_in = 4'd0;
  logic       en = 1'b0;
  logic       cnt_rst = 1'b0;
  logic       clr_err = 1'b0;
  logic       locked;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;
  logic       err;
  logic [7:0] err_cnt;
  logic [3:0] last_bad;
  logic [22:0] obs;

  int checks = 0;
  int errors = 0;

  int m_prev, m_streak, m_wc, m_ec, m_lb;
  bit m_acq, m_lk, m_wp, m_err;

  count_monitor #(.LOCK_N(LOCK_N)) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .en(en),
    .cnt_rst(cnt_rst), .clr_err(clr_err), .locked(locked),
    .wrap_pulse(wrap_pulse), .wrap_cnt(wrap_cnt), .err(err),
    .err_cnt(err_cnt), .last_bad(last_bad)
  );

  always #5 clk = ~clk;

  assign obs = {locked, wrap_pulse, wrap_cnt, err, err_cnt, last_bad};

  function automatic logic [22:0] expv();
    return {m_lk, m_wp, 8'(m_wc), m_err, 8'(m_ec), 4'(m_lb)};
  endfunction

  function automatic logic [3:0] nxt(input bit e);
    return e ? 4'((m_prev + 1) % 16) : 4'(m_prev);
  endfunction

  task automatic model_reset();
    m_prev = 0; m_streak = 0; m_wc = 0; m_ec = 0; m_lb = 0;
    m_acq = 1; m_lk = 0; m_wp = 0; m_err = 0;
  endtask

  task automatic step(input logic [3:0] q, input bit e,
                      input bit cr, input bit ce);
    int  ev;
    bit  good;
    q_in = q; en = e; cnt_rst = cr; clr_err = ce;
    @(posedge clk);
    ev   = e ? (m_prev + 1) % 16 : m_prev;
    good = (int'(q) == ev);
    m_wp = 0;
    if (ce) begin m_err = 0; m_ec = 0; m_lb = 0; end
    if (cr) begin
      m_acq = 1; m_streak = 0; m_lk = 0;
    end else if (m_acq) begin
      m_acq = 0; m_streak = 0;
    end else begin
      if (m_prev == 15 && e && q == 0) begin
        m_wp = 1;
        if (m_wc < 255) m_wc++;
      end
      if (m_lk) begin
        if (!good) begin
          m_err = 1; m_lb = int'(q); m_lk = 0; m_streak = 0;
          if (m_ec < 255) m_ec++;
        end
      end else if (good) begin
        m_streak++;
        if (m_streak == LOCK_N) m_lk = 1;
      end else begin
        m_streak = 0;
      end
    end
    m_prev = int'(q);
    #1;
    cnt_rst = 1'b0; clr_err = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("FAIL reset: got %h want 0", obs);
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    for (int v = 0; v <= 5; v++) begin
      step(4'(v), 1, 0, 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL lock q=%0d: got %h want %h", v, obs, expv());
      end
      if (v == 4) begin
        checks++;
        if (locked !== 1'b1 || err !== 1'b0) begin
          errors++;
          $display("FAIL lock_at4: locked=%b err=%b want 1 0",
                   locked, err);
        end
      end
    end
  endtask

  task automatic test_wrap();
    for (int v = 6; v <= 15; v++) step(4'(v), 1, 0, 0);
    step(4'd0, 1, 0, 0);
    checks++;
    if (wrap_pulse !== 1'b1 || wrap_cnt !== 8'd1 || obs !== expv()) begin
      errors++;
      $display("FAIL wrap: pulse=%b cnt=%0d want 1 1",
               wrap_pulse, wrap_cnt);
    end
    step(4'd1, 1, 0, 0);
    checks++;
    if (wrap_pulse !== 1'b0 || wrap_cnt !== 8'd1) begin
      errors++;
      $display("FAIL wrap_once: pulse=%b cnt=%0d want 0 1",
               wrap_pulse, wrap_cnt);
    end
  endtask

  task automatic test_mismatch();
    for (int v = 2; v <= 6; v++) step(4'(v), 1, 0, 0);
    step(4'd9, 1, 0, 0);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || last_bad !== 4'd9
        || locked !== 1'b0) begin
      errors++;
      $display("FAIL mismatch: err=%b cnt=%0d bad=%0d lk=%b want 1 1 9 0",
               err, err_cnt, last_bad, locked);
    end
    for (int v = 10; v <= 13; v++) step(4'(v), 1, 0, 0);
    checks++;
    if (locked !== 1'b1 || err !== 1'b1 || obs !== expv()) begin
      errors++;
      $display("FAIL relock: lk=%b err=%b want 1 1", locked, err);
    end
  endtask

  task automatic test_cnt_rst();
    step(4'd14, 1, 0, 0);
    step(4'd15, 1, 0, 0);
    for (int v = 0; v <= 7; v++) step(4'(v), 1, 0, 0);
    step(4'd0, 1, 1, 0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'd1 || obs !== expv()) begin
      errors++;
      $display("FAIL cnt_rst: lk=%b ecnt=%0d want 0 1", locked, err_cnt);
    end
    for (int v = 1; v <= 4; v++) step(4'(v), 1, 0, 0);
    checks++;
    if (locked !== 1'b0 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL cnt_rst_acq: lk=%b ecnt=%0d want 0 1",
               locked, err_cnt);
    end
    step(4'd5, 1, 0, 0);
    checks++;
    if (locked !== 1'b1 || obs !== expv()) begin
      errors++;
      $display("FAIL cnt_rst_relock: got %h want %h", obs, expv());
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      step(4'd5, 0, 0, 0);
      checks++;
      if (locked !== 1'b1) begin
        errors++;
        $display("FAIL hold%0d: locked=%b want 1", i, locked);
      end
    end
    step(4'd6, 0, 0, 0);
    checks++;
    if (err_cnt !== 8'd2 || locked !== 1'b0 || last_bad !== 4'd6) begin
      errors++;
      $display("FAIL hold_bad: ecnt=%0d lk=%b bad=%0d want 2 0 6",
               err_cnt, locked, last_bad);
    end
  endtask

  task automatic relock_and_miss(input bit ce);
    for (int i = 0; i < LOCK_N; i++) step(nxt(1), 1, 0, 0);
    step(4'(nxt(1) + 4'd3), 1, 0, ce);
  endtask

  task automatic test_saturate();
    while (m_ec < 255) relock_and_miss(0);
    checks++;
    if (err_cnt !== 8'd255 || obs !== expv()) begin
      errors++;
      $display("FAIL sat_reach: ecnt=%0d want 255", err_cnt);
    end
    relock_and_miss(0);
    checks++;
    if (err_cnt !== 8'd255) begin
      errors++;
      $display("FAIL sat_hold: ecnt=%0d want 255", err_cnt);
    end
    step(nxt(1), 1, 0, 1);
    checks++;
    if (err !== 1'b0 || err_cnt !== 8'd0 || last_bad !== 4'd0) begin
      errors++;
      $display("FAIL clr: err=%b ecnt=%0d bad=%0d want 0 0 0",
               err, err_cnt, last_bad);
    end
    relock_and_miss(1);
    checks++;
    if (err !== 1'b1 || err_cnt !== 8'd1 || obs !== expv()) begin
      errors++;
      $display("FAIL clr_vs_miss: err=%b ecnt=%0d want 1 1", err, err_cnt);
    end
    for (int i = 0; i < LOCK_N; i++) step(nxt(1), 1, 0, 0);
    q_in = 4'd3; en = 1'b1; cnt_rst = 1'b1; clr_err = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== 23'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want 0", obs);
    end
    model_reset();
    cnt_rst = 1'b0; clr_err = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_random();
    bit e;
    logic [3:0] q;
    for (int i = 0; i < 3000; i++) begin
      e = ($urandom_range(0, 3) != 0);
      q = ($urandom_range(0, 9) < 8) ? nxt(e) : 4'($urandom_range(0, 15));
      step(q, e, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      checks++;
      if (obs !== expv()) begin
        errors++;
        $display("FAIL random%0d: got %h want %h", i, obs, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_mismatch();
    test_cnt_rst();
    test_hold();
    test_saturate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
